redmule_job_ctx_regfile: RTL and testbench
==========================================

// Module: redmule_job_ctx_regfile
// PURPOSE
//  Multi-context job register file between the peripheral (config) bus and the RedMulE scheduler.
//  Software acquires a free context, programs N_REGS job words (X/W/Y/Z addr, iters, strides, OP_SELECTION), triggers.
//  Contexts are queued in a ring and presented in order to the scheduler; the next job is programmed while the current runs.
// PARAMETERS
//  N_CONTEXT  2   number of job contexts (power of 2, >=1)
//  N_REGS     19  32-bit job registers per context
//  ADDR_W     8   byte address width; addr_i[ADDR_W-1] selects job space (1) or control space (0)
// PORTS
//  clk_i        in   1               clock
//  rst_i        in   1               synchronous active-high reset
//  req_i        in   1               bus request
//  we_i         in   1               1=write, 0=read
//  addr_i       in   ADDR_W          byte address; word index = addr_i[ADDR_W-2:2]
//  be_i         in   4               write byte enables
//  wdata_i      in   32              write data
//  gnt_o        out  1               grant, combinational = req_i
//  r_valid_o    out  1               read/write response valid, 1 cycle after grant
//  rdata_o      out  32              read data, valid with r_valid_o
//  job_valid_o  out  1               head context ready for execution
//  job_ready_i  in   1               scheduler accepts head job
//  job_regs_o   out  N_REGS*32       register words of head context (stable while job_valid_o or running)
//  job_ctx_o    out  $clog2(N_CONTEXT)+1  id of head context
//  done_i       in   1               scheduler finished running job (1-cycle pulse)
//  evt_o        out  1               1-cycle completion event
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (mod N_CONTEXT), count (0..N_CONTEXT), acquired, running. Reset: all 0; all outputs 0; regs 0.
//  Control words: 0 TRIGGER(W), 1 ACQUIRE(R), 2 STATUS(R), 3 RUNNING_CTX(R), 4 SOFT_CLEAR(W), 5 JOB_CYCLES(R).
//  ACQUIRE read: if !acquired && count<N_CONTEXT -> rdata=wr_ptr, acquired<=1; if acquired -> rdata=wr_ptr again;
//   if count==N_CONTEXT -> rdata=32'hFFFF_FFFF, no state change.
//  Job write (addr_i[ADDR_W-1]=1, idx<N_REGS): ctx[wr_ptr][idx] updated per be_i only if acquired; else dropped.
//   idx>=N_REGS: write dropped, read returns 0. Job reads return ctx[wr_ptr][idx].
//  TRIGGER write: if acquired -> count+1, wr_ptr+1, acquired<=0; else ignored.
//  STATUS = {16'b0, 4'(count), 2'b0, acquired, running, 8'(rd_ptr)}; RUNNING_CTX = rd_ptr.
//  job_valid_o = count>0 && !running. job_valid_o&&job_ready_i -> running<=1 next cycle.
//  done_i while running -> running<=0, rd_ptr+1, count-1, evt_o=1 next cycle; done_i while !running ignored.
//  TRIGGER and done_i in same cycle -> count unchanged net, both pointers advance.
//  Unused control words: writes ignored, reads 0. Bus never stalls (gnt_o=req_i).
//  SOFT_CLEAR write or rst_i at any time (incl. mid-job): pointers, count, acquired, running, evt_o, regs -> 0 next cycle;
//   scheduler must treat it as abort; done_i in that cycle ignored.
//  Head context registers written by software only if acquired ctx == rd_ptr, impossible while count>0 (ring full guard).
// CONFIGURATION
//  REDMULE_JOB_PERF_EN defined: 32-bit counter cleared on job accept, +1 each cycle while running, saturates at
//   32'hFFFF_FFFF; value frozen at done_i; JOB_CYCLES returns it. Undefined: no counter, JOB_CYCLES reads 0.
// TESTING
//  Reset -> STATUS=0, job_valid_o=0, ACQUIRE read returns 0.
//  Acquire, write word 0=0x1000_0000 be=4'b0011, trigger -> job_valid_o=1, job_regs_o[0]=0x0000_0000(be)/full be ->0x1000_0000.
//  N_CONTEXT=2: acquire+trigger twice, third ACQUIRE -> 0xFFFF_FFFF; done_i -> evt_o pulse, next ACQUIRE -> 0.
//  Job accepted, done_i same cycle as TRIGGER of ctx 1 -> count stays 1, job_ctx_o=1, job_valid_o=1 next cycle.
//  SOFT_CLEAR while running -> running=0, count=0, job_valid_o=0, all job regs read 0, no evt_o.
//  With REDMULE_JOB_PERF_EN: job runs 37 cycles -> JOB_CYCLES=37; without macro -> 0.

Source files
------------

// File: rtl/redmule_job_ctx_regfile.sv
// rtl/redmule_job_ctx_regfile.sv - multi-context RedMulE job register ring; optional cycle counter via REDMULE_JOB_PERF_EN
module redmule_job_ctx_regfile #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_REGS    = 19,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [3:0]                    be_i,
    input  logic [31:0]                   wdata_i,
    output logic                          gnt_o,
    output logic                          r_valid_o,
    output logic [31:0]                   rdata_o,
    output logic                          job_valid_o,
    input  logic                          job_ready_i,
    output logic [N_REGS*32-1:0]          job_regs_o,
    output logic [$clog2(N_CONTEXT):0]    job_ctx_o,
    input  logic                          done_i,
    output logic                          evt_o
);

    localparam int unsigned PTR_W = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
    localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);
    localparam int unsigned CTX_W = $clog2(N_CONTEXT) + 1;
    localparam int unsigned IDX_W = ADDR_W - 3;

    localparam logic [IDX_W-1:0] IDX_TRIGGER = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ACQUIRE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_RUN_CTX = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_CLEAR   = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_CYCLES  = IDX_W'(5);

    logic [31:0]      ctx_q [N_CONTEXT][N_REGS];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             acquired_q;
    logic             running_q;

    logic [IDX_W-1:0] idx;
    logic             job_space;
    logic             idx_in_range;
    logic             ctl_wr;
    logic             ctl_rd;
    logic             acquire_rd;
    logic             trigger;
    logic             soft_clear;
    logic             full;
    logic             job_wr;
    logic             job_accept;
    logic             job_done;
    logic [31:0]      rdata_d;
    logic [31:0]      job_cycles;
    logic [3:0]       count_4;
    logic [7:0]       rd_ptr_8;
    logic             unused_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == N_CONTEXT - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx          = addr_i[ADDR_W-2:2];
    assign job_space    = addr_i[ADDR_W-1];
    assign unused_addr  = ^addr_i[1:0];
    assign idx_in_range = 32'(idx) < N_REGS;
    assign ctl_wr       = req_i && we_i && !job_space;
    assign ctl_rd       = req_i && !we_i && !job_space;
    assign acquire_rd   = ctl_rd && (idx == IDX_ACQUIRE);
    assign trigger      = ctl_wr && (idx == IDX_TRIGGER) && acquired_q;
    assign soft_clear   = ctl_wr && (idx == IDX_CLEAR);
    assign full         = (count_q == CNT_W'(N_CONTEXT));
    assign job_wr       = req_i && we_i && job_space && idx_in_range && acquired_q;
    assign job_valid_o  = (count_q != '0) && !running_q;
    assign job_accept   = job_valid_o && job_ready_i;
    assign job_done     = done_i && running_q;
    assign gnt_o        = req_i;
    assign job_ctx_o    = CTX_W'(rd_ptr_q);
    assign count_4      = 4'(count_q);
    assign rd_ptr_8     = 8'(rd_ptr_q);

    for (genvar r = 0; r < int'(N_REGS); r++) begin : g_job_regs
        assign job_regs_o[r*32 +: 32] = ctx_q[rd_ptr_q][r];
    end

    // Reads observe the state before this cycle's updates (acquire returns the slot it grants).
    always_comb begin
        rdata_d = '0;
        if (job_space) begin
            if (idx_in_range) begin
                rdata_d = ctx_q[wr_ptr_q][idx];
            end
        end else begin
            case (idx)
                IDX_ACQUIRE: rdata_d = (acquired_q || !full) ? 32'(wr_ptr_q) : 32'hFFFF_FFFF;
                IDX_STATUS:  rdata_d = {16'b0, count_4, 2'b0, acquired_q, running_q, rd_ptr_8};
                IDX_RUN_CTX: rdata_d = 32'(rd_ptr_q);
                IDX_CYCLES:  rdata_d = job_cycles;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            rdata_o   <= '0;
        end else begin
            r_valid_o <= req_i;
            rdata_o   <= (req_i && !we_i) ? rdata_d : '0;
        end
    end

    // Soft clear aborts everything, including a running job; its done_i is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i || soft_clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            acquired_q <= 1'b0;
            running_q  <= 1'b0;
            evt_o      <= 1'b0;
            for (int c = 0; c < int'(N_CONTEXT); c++) begin
                for (int r = 0; r < int'(N_REGS); r++) begin
                    ctx_q[c][r] <= '0;
                end
            end
        end else begin
            evt_o <= job_done;
            if (acquire_rd && !acquired_q && !full) begin
                acquired_q <= 1'b1;
            end
            if (trigger) begin
                wr_ptr_q   <= ptr_inc(wr_ptr_q);
                acquired_q <= 1'b0;
            end
            if (job_done) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (trigger && !job_done) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!trigger && job_done) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (job_accept) begin
                running_q <= 1'b1;
            end else if (job_done) begin
                running_q <= 1'b0;
            end
            if (job_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        ctx_q[wr_ptr_q][idx][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef REDMULE_JOB_PERF_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_clear) begin
            cycles_q <= '0;
        end else if (job_accept) begin
            cycles_q <= '0;
        end else if (running_q && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign job_cycles = cycles_q;
`else
    assign job_cycles = '0;
`endif

endmodule

// File: tb/tb_redmule_job_ctx_regfile.sv
// tb/tb_redmule_job_ctx_regfile.sv - directed and random bench for redmule_job_ctx_regfile with a queue-based job model
module tb_redmule_job_ctx_regfile;

    localparam int NC = 2;
    localparam int NR = 19;
    localparam int AW = 8;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               req_i = 1'b0;
    logic               we_i = 1'b0;
    logic [AW-1:0]      addr_i = '0;
    logic [3:0]         be_i = '0;
    logic [31:0]        wdata_i = '0;
    logic               gnt_o;
    logic               r_valid_o;
    logic [31:0]        rdata_o;
    logic               job_valid_o;
    logic               job_ready_i = 1'b0;
    logic [NR*32-1:0]   job_regs_o;
    logic [$clog2(NC):0] job_ctx_o;
    logic               done_i = 1'b0;
    logic               evt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;

    logic [31:0] mem [NC][NR];
    int          jobq[$];
    int          next_id;
    bit          macq;
    bit          mrun;
    bit          mevt;
    logic [31:0] mcycles;

    always #5 clk_i = ~clk_i;

    redmule_job_ctx_regfile #(
        .N_CONTEXT(NC),
        .N_REGS(NR),
        .ADDR_W(AW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .be_i(be_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o),
        .r_valid_o(r_valid_o),
        .rdata_o(rdata_o),
        .job_valid_o(job_valid_o),
        .job_ready_i(job_ready_i),
        .job_regs_o(job_regs_o),
        .job_ctx_o(job_ctx_o),
        .done_i(done_i),
        .evt_o(evt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [NR*32-1:0] obs, input logic [NR*32-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                mem[c][r] = '0;
        jobq.delete();
        next_id = 0;
        macq = 0;
        mrun = 0;
        mevt = 0;
        mcycles = '0;
    endtask

    function automatic int head_id();
        return (jobq.size() > 0) ? jobq[0] : next_id;
    endfunction

    function automatic logic [31:0] model_read(input bit job, input int idx);
        if (job) return (idx < NR) ? mem[next_id][idx] : 32'h0;
        case (idx)
            1: return (macq || jobq.size() < NC) ? 32'(next_id) : 32'hFFFF_FFFF;
            2: return (32'(jobq.size()) << 12) | (32'(macq) << 9) | (32'(mrun) << 8) | 32'(head_id());
            3: return 32'(head_id());
`ifdef REDMULE_JOB_PERF_EN
            5: return mcycles;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive bus/scheduler inputs, advance the model, compare every output.
    task automatic cycle_op(input bit req, input bit we, input bit job, input int idx,
                            input logic [3:0] be, input logic [31:0] wd, input bit done, input bit ready);
        logic [31:0] exp_rd;
        logic [NR*32-1:0] exp_regs;
        bit accept, dn, clr;
        req_i = req;
        we_i = we;
        addr_i = (job ? 8'h80 : 8'h00) | 8'((idx & 31) << 2);
        be_i = be;
        wdata_i = wd;
        done_i = done;
        job_ready_i = ready;
        exp_rd = (req && !we) ? model_read(job, idx) : 32'h0;
        accept = (jobq.size() > 0) && !mrun && ready;
        dn = done && mrun;
        clr = req && we && !job && idx == 4;
        @(posedge clk_i);
        if (clr) begin
            model_clear();
        end else begin
            mevt = dn;
            if (accept) mcycles = '0;
            else if (mrun && mcycles != 32'hFFFF_FFFF) mcycles = mcycles + 1;
            if (req && !we && !job && idx == 1 && !macq && jobq.size() < NC) macq = 1;
            if (req && we && job && idx < NR && macq)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[next_id][idx][8*b +: 8] = wd[8*b +: 8];
            if (req && we && !job && idx == 0 && macq) begin
                jobq.push_back(next_id);
                next_id = (next_id + 1) % NC;
                macq = 0;
            end
            if (dn) begin
                void'(jobq.pop_front());
                mrun = 0;
            end
            if (accept) mrun = 1;
        end
        #1;
        last_rdata = rdata_o;
        check("r_valid", {31'b0, r_valid_o}, {31'b0, req});
        if (req && !we) check("rdata", rdata_o, exp_rd);
        check("job_valid", {31'b0, job_valid_o}, {31'b0, jobq.size() > 0 && !mrun});
        check("job_ctx", 32'(job_ctx_o), 32'(head_id()));
        check("evt", {31'b0, evt_o}, {31'b0, mevt});
        for (int r = 0; r < NR; r++) exp_regs[r*32 +: 32] = mem[head_id()][r];
        check_wide("job_regs", job_regs_o, exp_regs);
        req_i = 0;
        we_i = 0;
        done_i = 0;
        job_ready_i = 0;
    endtask

    task automatic rd_ctl(input int idx);                 cycle_op(1, 0, 0, idx, 4'h0, 32'h0, 0, 0); endtask
    task automatic wr_ctl(input int idx, input logic [31:0] wd); cycle_op(1, 1, 0, idx, 4'hF, wd, 0, 0); endtask
    task automatic rd_job(input int idx);                 cycle_op(1, 0, 1, idx, 4'h0, 32'h0, 0, 0); endtask
    task automatic wr_job(input int idx, input logic [3:0] be, input logic [31:0] wd); cycle_op(1, 1, 1, idx, be, wd, 0, 0); endtask
    task automatic idle(input bit done, input bit ready); cycle_op(0, 0, 0, 0, 4'h0, 32'h0, done, ready); endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 0;
        check("rst_r_valid", {31'b0, r_valid_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_job_valid", {31'b0, job_valid_o}, 32'h0);
        check("rst_evt", {31'b0, evt_o}, 32'h0);
        check("rst_job_ctx", 32'(job_ctx_o), 32'h0);
        check("rst_gnt", {31'b0, gnt_o}, 32'h0);
        check_wide("rst_job_regs", job_regs_o, '0);

        rd_ctl(2);  check("rst_status", last_rdata, 32'h0);
        rd_ctl(1);  check("first_acquire", last_rdata, 32'h0);
        wr_job(0, 4'b0011, 32'h1000_0000);
        rd_job(0);  check("be_partial", last_rdata, 32'h0);
        wr_job(0, 4'hF, 32'h1000_0000);
        for (int i = 1; i < NR; i++) wr_job(i, 4'($urandom_range(0, 15)), $urandom);
        wr_ctl(0, 32'h0);
        check("trig_valid", {31'b0, job_valid_o}, 32'h1);
        check("trig_word0", job_regs_o[31:0], 32'h1000_0000);

        // Overlap: ctx 0 running, ctx 1 triggered in the same cycle ctx 0 finishes.
        idle(0, 1);
        rd_ctl(1);  check("acq_ctx1", last_rdata, 32'h1);
        for (int i = 0; i < NR; i++) wr_job(i, 4'hF, $urandom);
        cycle_op(1, 1, 0, 0, 4'hF, 32'h0, 1, 0);
        check("overlap_ctx", 32'(job_ctx_o), 32'h1);
        check("overlap_valid", {31'b0, job_valid_o}, 32'h1);
        check("overlap_evt", {31'b0, evt_o}, 32'h1);
        rd_ctl(2);  check("overlap_count", 32'(last_rdata[15:12]), 32'h1);

        // Fill the ring, then free one slot.
        rd_ctl(1);
        wr_job(2, 4'hF, 32'hCAFE_0002);
        wr_ctl(0, 32'h0);
        rd_ctl(1);  check("acq_full", last_rdata, 32'hFFFF_FFFF);
        rd_ctl(2);  check("full_acquired", {31'b0, last_rdata[9]}, 32'h0);
        idle(0, 1);
        idle(1, 0); check("done_evt", {31'b0, evt_o}, 32'h1);
        idle(0, 0); check("evt_pulse", {31'b0, evt_o}, 32'h0);
        rd_ctl(1);

        // Timed job: 37 cycles of running.
        idle(0, 1);
        repeat (36) idle(0, 0);
        idle(1, 0);
        rd_ctl(5);
`ifdef REDMULE_JOB_PERF_EN
        check("job_cycles", last_rdata, 32'd37);
`else
        check("job_cycles", last_rdata, 32'd0);
`endif

        // Boundaries: out-of-range job words, unused control words, trigger without acquire.
        rd_job(NR);  check("job_oor_rd", last_rdata, 32'h0);
        wr_job(NR, 4'hF, 32'hDEAD_BEEF);
        rd_job(NR);  check("job_oor_wr", last_rdata, 32'h0);
        rd_ctl(7);   check("ctl_unused", last_rdata, 32'h0);
        rd_ctl(0);   check("ctl_trigger_rd", last_rdata, 32'h0);
        wr_ctl(0, 32'h0);
        wr_ctl(0, 32'h0);
        wr_job(3, 4'hF, 32'h1234_5678);
        rd_ctl(2);

        for (int it = 0; it < 300; it++) begin
            int op;
            int ix;
            bit d;
            bit r;
            op = $urandom_range(0, 9);
            ix = $urandom_range(0, NR + 2);
            d = ($urandom_range(0, 3) == 0);
            r = 1'($urandom_range(0, 1));
            case (op)
                0:       cycle_op(1, 0, 0, 1, 4'h0, 32'h0, d, r);
                1, 2, 3: cycle_op(1, 1, 1, ix, 4'($urandom_range(0, 15)), $urandom, d, r);
                4:       cycle_op(1, 0, 1, ix, 4'h0, 32'h0, d, r);
                5, 6:    cycle_op(1, 1, 0, 0, 4'hF, $urandom, d, r);
                7:       cycle_op(1, 0, 0, $urandom_range(0, 7), 4'h0, 32'h0, d, r);
                default: cycle_op(0, 0, 0, 0, 4'h0, 32'h0, d, r);
            endcase
        end

        // Soft clear in the middle of a running job, with a coincident done_i.
        if (!mrun) begin
            if (jobq.size() == 0) begin
                if (!macq) rd_ctl(1);
                wr_ctl(0, 32'h0);
            end
            idle(0, 1);
        end
        rd_ctl(2);  check("pre_clear_running", {31'b0, last_rdata[8]}, 32'h1);
        cycle_op(1, 1, 0, 4, 4'hF, 32'hFFFF_FFFF, 1, 0);
        check("clear_evt", {31'b0, evt_o}, 32'h0);
        check("clear_valid", {31'b0, job_valid_o}, 32'h0);
        check_wide("clear_job_regs", job_regs_o, '0);
        rd_ctl(2);  check("clear_status", last_rdata, 32'h0);
        rd_ctl(1);  check("clear_acquire", last_rdata, 32'h0);
        for (int i = 0; i < NR; i++) begin
            rd_job(i);
            check("clear_word", last_rdata, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
